// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: round-robin sharing of one combinational ALU between two
// valid/ready requesters. One operation is in flight at a time. Its operands
// are registered into the ALU, the result is captured one cycle later, and the
// response is held until the owning requester takes it.
`timescale 1ns/1ps
module alu_share_arbiter #(
  parameter int DATA_W = 32,
  parameter int OP_W   = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [OP_W-1:0]   req0_op,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [OP_W-1:0]   req1_op,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,
  output logic              rsp0_valid,
  input  logic              rsp0_ready,
  output logic [DATA_W-1:0] rsp0_result,
  output logic              rsp0_zero,
  output logic              rsp1_valid,
  input  logic              rsp1_ready,
  output logic [DATA_W-1:0] rsp1_result,
  output logic              rsp1_zero,
  output logic [OP_W-1:0]   alu_ctrl,
  output logic [DATA_W-1:0] alu_src_a,
  output logic [DATA_W-1:0] alu_src_b,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              alu_zero,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t              state_q, state_d;
  logic                lastGrant_q;
  logic                owner_q;
  logic [OP_W-1:0]     op_q;
  logic [DATA_W-1:0]   srcA_q;
  logic [DATA_W-1:0]   srcB_q;
  logic [DATA_W-1:0]   result_q;
  logic                zero_q;

  logic                grant;
  logic                accept;
  logic                rspDone;

  // State register; reset aborts whatever operation is in flight
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state: accept in IDLE, one execute cycle, then wait for the owner to take the result
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept)  state_d = EXEC;
      EXEC:                 state_d = RESP;
      RESP:    if (rspDone) state_d = IDLE;
      default:              state_d = IDLE;
    endcase
  end

  // Outputs: round-robin grant favours the requester that was not served last; only the owner's response is valid
  always_comb begin
    if (req0_valid && req1_valid) grant = ~lastGrant_q;
    else                          grant = req1_valid;
    req0_ready = (state_q == IDLE) && req0_valid && !grant;
    req1_ready = (state_q == IDLE) && req1_valid &&  grant;
    accept     = req0_ready || req1_ready;
    rsp0_valid = (state_q == RESP) && !owner_q;
    rsp1_valid = (state_q == RESP) &&  owner_q;
    rspDone    = (rsp0_valid && rsp0_ready) || (rsp1_valid && rsp1_ready);
    busy       = (state_q != IDLE);
  end

  // Datapath registers: operands on accept, ALU result at end of EXEC, fairness pointer on response handoff
  always_ff @(posedge clk) begin
    if (reset) begin
      lastGrant_q <= 1'b1;
      owner_q     <= 1'b0;
      op_q        <= '0;
      srcA_q      <= '0;
      srcB_q      <= '0;
      result_q    <= '0;
      zero_q      <= 1'b0;
    end else begin
      if (accept) begin
        owner_q <= req1_ready;
        op_q    <= req1_ready ? req1_op : req0_op;
        srcA_q  <= req1_ready ? req1_a  : req0_a;
        srcB_q  <= req1_ready ? req1_b  : req0_b;
      end
      if (state_q == EXEC) begin
        result_q <= alu_result;
        zero_q   <= alu_zero;
      end
      if (rspDone) lastGrant_q <= owner_q;
    end
  end

  assign alu_ctrl    = op_q;
  assign alu_src_a   = srcA_q;
  assign alu_src_b   = srcB_q;
  assign rsp0_result = result_q;
  assign rsp0_zero   = zero_q;
  assign rsp1_result = result_q;
  assign rsp1_zero   = zero_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// tb_alu_share_arbiter: directed checks of the shared-ALU arbiter with a small
// behavioural ALU hooked to its ALU-side ports.
`timescale 1ns/1ps
module tb_alu_share_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req0_valid = 1'b0, req1_valid = 1'b0;
  logic        req0_ready, req1_ready;
  logic [2:0]  req0_op = '0, req1_op = '0;
  logic [31:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic        rsp0_valid, rsp1_valid;
  logic        rsp0_ready = 1'b0, rsp1_ready = 1'b0;
  logic [31:0] rsp0_result, rsp1_result;
  logic        rsp0_zero, rsp1_zero;
  logic [2:0]  alu_ctrl;
  logic [31:0] alu_src_a, alu_src_b, alu_result;
  logic        alu_zero;
  logic        busy;

  int vectors = 0;
  int miscompares = 0;

  alu_share_arbiter #(.DATA_W(32), .OP_W(3)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op), .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op), .req1_a(req1_a), .req1_b(req1_b),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_result(rsp0_result), .rsp0_zero(rsp0_zero),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_result(rsp1_result), .rsp1_zero(rsp1_zero),
    .alu_ctrl(alu_ctrl), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .alu_result(alu_result), .alu_zero(alu_zero), .busy(busy)
  );

  always #5 clk = ~clk;

  // Behavioural ALU: add, sub, and, or; codes 4..7 give 0; zero only for an equal subtract
  always_comb begin
    alu_result = 32'h0;
    alu_zero   = 1'b0;
    case (alu_ctrl)
      3'd0: alu_result = alu_src_a + alu_src_b;
      3'd1: begin
        alu_result = alu_src_a - alu_src_b;
        alu_zero   = (alu_src_a == alu_src_b);
      end
      3'd2: alu_result = alu_src_a & alu_src_b;
      3'd3: alu_result = alu_src_a | alu_src_b;
      default: alu_result = 32'h0;
    endcase
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic applyStimulus(input logic v0, input logic [2:0] op0, input logic [31:0] a0, input logic [31:0] b0,
                               input logic v1, input logic [2:0] op1, input logic [31:0] a1, input logic [31:0] b1);
    req0_valid = v0; req0_op = op0; req0_a = a0; req0_b = b0;
    req1_valid = v1; req1_op = op1; req1_a = a1; req1_b = b1;
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed=0x%08h expected=0x%08h", tag, observed, expected);
    end
  endtask

  // One uncontended operation through requester 'port', response taken immediately
  task automatic runSingle(input int port, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] expRes, input logic expZero, input string tag);
    if (port == 0) applyStimulus(1'b1, op, a, b, 1'b0, 3'd0, 32'h0, 32'h0);
    else           applyStimulus(1'b0, 3'd0, 32'h0, 32'h0, 1'b1, op, a, b);
    checkOutput({tag, "_ready"}, {30'h0, req1_ready, req0_ready}, (port == 0) ? 32'h1 : 32'h2);
    tick();
    applyStimulus(1'b0, 3'd0, 32'h0, 32'h0, 1'b0, 3'd0, 32'h0, 32'h0);
    checkOutput({tag, "_exec_ctrl"}, {29'h0, alu_ctrl}, {29'h0, op});
    checkOutput({tag, "_exec_a"}, alu_src_a, a);
    checkOutput({tag, "_exec_b"}, alu_src_b, b);
    checkOutput({tag, "_exec_busy_rspv"}, {29'h0, busy, rsp1_valid, rsp0_valid}, 32'h4);
    tick();
    checkOutput({tag, "_resp_valid"}, {29'h0, busy, rsp1_valid, rsp0_valid}, (port == 0) ? 32'h5 : 32'h6);
    checkOutput({tag, "_resp_result"}, (port == 0) ? rsp0_result : rsp1_result, expRes);
    checkOutput({tag, "_resp_zero"}, {31'h0, (port == 0) ? rsp0_zero : rsp1_zero}, {31'h0, expZero});
    if (port == 0) rsp0_ready = 1'b1; else rsp1_ready = 1'b1;
    tick();
    checkOutput({tag, "_back_idle"}, {29'h0, busy, rsp1_valid, rsp0_valid}, 32'h0);
    rsp0_ready = 1'b0;
    rsp1_ready = 1'b0;
  endtask

  task automatic doReset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    #1;
  endtask

  initial begin
    $display("[TB] starting alu_share_arbiter directed test");
    doReset();
    checkOutput("reset_busy_rspv", {29'h0, busy, rsp1_valid, rsp0_valid}, 32'h0);
    checkOutput("reset_alu_ctrl", {29'h0, alu_ctrl}, 32'h0);
    checkOutput("reset_alu_a", alu_src_a, 32'h0);
    checkOutput("reset_alu_b", alu_src_b, 32'h0);
    checkOutput("reset_ready", {30'h0, req1_ready, req0_ready}, 32'h0);

    runSingle(0, 3'd0, 32'd5, 32'd7, 32'd12, 1'b0, "add");
    runSingle(1, 3'd1, 32'h1234, 32'h1234, 32'h0, 1'b1, "sub_eq");
    runSingle(1, 3'd1, 32'd3, 32'd5, 32'hFFFF_FFFE, 1'b0, "sub_neg");

    // Continuous contention after reset: grants alternate 0,1,0,1 every three cycles
    doReset();
    rsp0_ready = 1'b1;
    rsp1_ready = 1'b1;
    applyStimulus(1'b1, 3'd2, 32'hF0F0, 32'hFF00, 1'b1, 3'd3, 32'h0F, 32'hF0);
    for (int k = 0; k < 4; k++) begin
      checkOutput("rr_grant", {30'h0, req1_ready, req0_ready}, (k % 2 == 0) ? 32'h1 : 32'h2);
      tick();
      checkOutput("rr_exec_a", alu_src_a, (k % 2 == 0) ? 32'hF0F0 : 32'h0F);
      checkOutput("rr_exec_ready", {29'h0, busy, req1_ready, req0_ready}, 32'h4);
      tick();
      checkOutput("rr_resp_valid", {30'h0, rsp1_valid, rsp0_valid}, (k % 2 == 0) ? 32'h1 : 32'h2);
      checkOutput("rr_resp_result", (k % 2 == 0) ? rsp0_result : rsp1_result, (k % 2 == 0) ? 32'hF000 : 32'hFF);
      tick();
    end
    rsp0_ready = 1'b0;
    rsp1_ready = 1'b0;
    applyStimulus(1'b0, 3'd0, 32'h0, 32'h0, 1'b0, 3'd0, 32'h0, 32'h0);

    // Backpressure: owner 0 holds off, non-owner ready must be ignored
    doReset();
    applyStimulus(1'b1, 3'd0, 32'd10, 32'd20, 1'b1, 3'd0, 32'd1, 32'd2);
    checkOutput("bp_grant", {30'h0, req1_ready, req0_ready}, 32'h1);
    rsp1_ready = 1'b1;
    tick();
    tick();
    for (int k = 0; k < 5; k++) begin
      checkOutput("bp_hold_valid", {29'h0, req1_ready, rsp1_valid, rsp0_valid}, 32'h1);
      checkOutput("bp_hold_result", rsp0_result, 32'd30);
      tick();
    end
    rsp0_ready = 1'b1;
    tick();
    checkOutput("bp_release", {28'h0, busy, req1_ready, rsp0_valid, req0_ready}, 32'h4);
    tick();
    tick();
    checkOutput("bp_r1_result", {31'h0, rsp1_valid}, 32'h1);
    checkOutput("bp_r1_value", rsp1_result, 32'd3);
    applyStimulus(1'b0, 3'd0, 32'h0, 32'h0, 1'b0, 3'd0, 32'h0, 32'h0);
    tick();
    rsp0_ready = 1'b0;
    rsp1_ready = 1'b0;

    runSingle(0, 3'd6, 32'd1, 32'd1, 32'h0, 1'b0, "op6");

    // Reset during EXEC of a requester-1 op; last grant was requester 0
    applyStimulus(1'b0, 3'd0, 32'h0, 32'h0, 1'b1, 3'd5, 32'd9, 32'd9);
    checkOutput("mid_grant", {30'h0, req1_ready, req0_ready}, 32'h2);
    tick();
    applyStimulus(1'b0, 3'd0, 32'h0, 32'h0, 1'b0, 3'd0, 32'h0, 32'h0);
    checkOutput("mid_exec_ctrl", {29'h0, alu_ctrl}, 32'h5);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    checkOutput("mid_reset_state", {29'h0, busy, rsp1_valid, rsp0_valid}, 32'h0);
    checkOutput("mid_reset_ctrl", {29'h0, alu_ctrl}, 32'h0);
    checkOutput("mid_reset_a", alu_src_a, 32'h0);
    tick();
    checkOutput("mid_no_rsp", {29'h0, busy, rsp1_valid, rsp0_valid}, 32'h0);
    applyStimulus(1'b1, 3'd0, 32'h0, 32'h0, 1'b1, 3'd0, 32'h0, 32'h0);
    checkOutput("mid_after_grant", {30'h0, req1_ready, req0_ready}, 32'h1);
    applyStimulus(1'b0, 3'd0, 32'h0, 32'h0, 1'b0, 3'd0, 32'h0, 32'h0);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/alu_share_arbiter.md
Name: alu_share_arbiter

Overview:
Shares the single combinational ALU between two requesters (e.g. the execute datapath and an address/branch helper) using round-robin arbitration and valid/ready handshakes. It accepts one operation at a time and registers the operands into the ALU. It captures the ALU result and zero flag one cycle later and holds the response until the owning requester accepts it. It sits between the requesters and the ALU instance and owns the ALU's ALUControl/SrcA/SrcB inputs.

Parameters:
DATA_W, 32, operand/result width (matches ALU SrcA/SrcB/ALUResult)
OP_W, 3, ALU control width (matches ALUControl)

Ports:
clk  in  1  clock, rising edge
reset  in  1  synchronous, active-high reset
req0_valid  in  1  requester 0 has an operation
req0_ready  out  1  arbiter accepts requester 0 this cycle
req0_op  in  OP_W  ALU control code for requester 0
req0_a  in  DATA_W  operand A for requester 0
req0_b  in  DATA_W  operand B for requester 0
req1_valid / req1_ready / req1_op / req1_a / req1_b  same widths and meaning, requester 1
rsp0_valid  out  1  result available for requester 0
rsp0_ready  in  1  requester 0 consumes result
rsp0_result  out  DATA_W  captured ALU result
rsp0_zero  out  1  captured ALU zero flag
rsp1_valid / rsp1_ready / rsp1_result / rsp1_zero  same, requester 1
alu_ctrl  out  OP_W  to ALU ALUControl
alu_src_a  out  DATA_W  to ALU SrcA
alu_src_b  out  DATA_W  to ALU SrcB
alu_result  in  DATA_W  from ALU ALUResult
alu_zero  in  1  from ALU zero_flag
busy  out  1  high whenever state != IDLE

Behaviour:
- Single clock clk; reset is synchronous and active-high; all state updates happen on the rising edge of clk.
- Reset values: state=IDLE, last_grant=1 (requester 0 wins the first contention), op/operand registers=0 (so alu_ctrl=0, alu_src_a=0, alu_src_b=0), result/zero registers=0, rsp0_valid=rsp1_valid=0, busy=0.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - grant is combinational.
  - Only one valid: grant goes to that requester.
  - Both valid: grant goes to the requester != last_grant.
  - reqN_ready = (state==IDLE) && reqN_valid && grant==N. At most one ready is high per cycle.
  - On handshake: latch op/a/b into the registers, record owner=N, go to EXEC.
  - No valid: stay in IDLE.
- EXEC: the ALU sees the registered operands for the whole cycle. At the clock edge, latch alu_result and alu_zero into the result registers and go to RESP.
- RESP:
  - rsp<owner>_valid=1; the other rsp_valid stays 0.
  - When rsp<owner>_ready=1: last_grant<=owner, rsp_valid drops next cycle, go to IDLE.
  - rsp_ready on the non-owner port is ignored.
- ALU drive: alu_ctrl/alu_src_a/alu_src_b are always driven from the registers (no combinational path from req inputs to the ALU). The values hold after EXEC until the next accept.
- Latency:
  - accept (cycle T) -> rsp_valid high at cycle T+2.
  - With rsp_ready tied high: one operation per 3 cycles. A new accept is possible at T+3.
- Response hold: rspN_result and rspN_zero stay stable while rspN_valid=1. Both rsp result buses carry the same result register; only valid is steered.
- Op codes 4..7 are forwarded unchanged. The result is whatever the ALU returns (0). The zero flag is forwarded unchanged, and the ALU asserts it only for op 1 with an equal result.
- Width: no extension or truncation; DATA_W passes through unchanged.
- Requester rules: after asserting valid, the requester holds valid and payload stable until ready. The arbiter does not check for violations.
- Non-grant: a requester not granted keeps waiting. Arbitration is re-evaluated only in IDLE.
- Fairness: under continuous contention the grants alternate 0,1,0,1. A requester waits at most one full operation.
- Reset mid-operation (EXEC or RESP): the operation is aborted, no response is delivered, and state returns to the reset values next cycle.
- Simultaneous events: a requester whose rsp handshake completes in RESP can present its next request. That request is only considered in the following cycle (IDLE).

Test Plan:
- Single op: reset, req0 op=0 a=5 b=7 -> req0_ready at T, alu_ctrl=0/alu_src_a=5/alu_src_b=7 at T+1, rsp0_valid at T+2 with result=12, zero=0, busy=1 during T+1..T+2.
- Subtract to zero: req1 op=1 a=0x1234 b=0x1234 -> rsp1_valid, rsp1_result=0, rsp1_zero=1. Then op=1 a=3 b=5 -> result=0xFFFFFFFE, zero=0.
- Contention and round-robin: both valid continuously after reset with rsp_ready=1 -> grant order 0,1,0,1, accepts every 3 cycles, results matching each requester's operands (AND 0xF0F0&0xFF00=0xF000, OR 0x0F|0xF0=0xFF).
- Backpressure: rsp0_ready=0 for 5 cycles in RESP -> rsp0_valid and result held stable, req1_ready stays 0. Release -> IDLE next cycle, req1 granted.
- Unused op: op=6 a=1 b=1 -> result=0, zero=0.
- Reset mid-op: assert reset during EXEC -> next cycle rsp valids=0, busy=0, alu_ctrl=0. The next contention grants req0.
